// File: rtl/seq_mult_pkg.sv
// Shared constants and state encoding for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = 5;

    localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One iteration step: the 33-bit partial sum shifted right, carry lands in the MSB.
    function automatic logic [PROD_W-1:0] shift_step(
        input logic              cout,
        input logic [WIDTH-1:0]  sum,
        input logic [PROD_W-1:0] p
    );
        return {cout, sum, p[WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/CLA_32bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module CLA_32bit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    always_comb begin
        logic [8:0] gc;
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       gg;
        logic       gp;

        gc    = '0;
        g     = '0;
        p     = '0;
        c     = '0;
        gg    = 1'b0;
        gp    = 1'b0;
        sum   = '0;
        gc[0] = cin;

        for (int i = 0; i < 8; i++) begin
            g    = A[4*i +: 4] & B[4*i +: 4];
            p    = A[4*i +: 4] ^ B[4*i +: 4];
            c[0] = gc[i];
            c[1] = g[0] | (p[0] & c[0]);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c[0]);
            gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
            gp   = &p;
            sum[4*i +: 4] = p ^ c;
            gc[i+1]       = gg | (gp & gc[i]);
        end
    end

    assign cout = gc_out(A, B, cin);

    // Final carry recomputed from group terms so cout has no dependence on the loop locals.
    function automatic logic gc_out(
        input logic [31:0] fa,
        input logic [31:0] fb,
        input logic        fc
    );
        logic       carry;
        logic [3:0] fg;
        logic [3:0] fp;
        carry = fc;
        for (int i = 0; i < 8; i++) begin
            fg    = fa[4*i +: 4] & fb[4*i +: 4];
            fp    = fa[4*i +: 4] ^ fb[4*i +: 4];
            carry = (fg[3] | (fp[3] & fg[2]) | (fp[3] & fp[2] & fg[1])
                  | (fp[3] & fp[2] & fp[1] & fg[0])) | ((&fp) & carry);
        end
        return carry;
    endfunction

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned 32x32->64 multiplier: one CLA_32bit reused over 32 shift-and-add steps.
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_m;
    logic [PROD_W-1:0]  r_p;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [PROD_W-1:0]  w_p_next;

    assign w_add_b  = r_p[0] ? r_m : WIDTH'(0);
    assign w_p_next = shift_step(w_cout, w_sum, r_p);

    CLA_32bit u_cla (
        .A    (r_p[PROD_W-1:WIDTH]),
        .B    (w_add_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_m     <= a;
                        r_p     <= {WIDTH'(0), b};
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Final step publishes the freshly computed accumulator on the same edge.
                    if (r_cnt == LAST_ITER) begin
                        product <= w_p_next;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: latency, arithmetic corners, ignored starts, async reset, back-to-back issue.
module tb_seq_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_checks;
    int n_pass;

    seq_mult_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Issue one multiply, then confirm busy, 32-edge latency, product and the single-cycle done.
    task automatic run_mult(input logic [31:0] ia, input logic [31:0] ib,
                            input logic [63:0] exp, input string tag);
        int lat;
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'd32);
        chk({tag, "_prod"}, product, exp);
        @(posedge clk);
        #1;
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_done;
        int n_busy;
        int unstable;
        int e;
        int done_edge[4];

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_mult(32'd3, 32'd5, 64'd15, "m3x5");
        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mff");
        run_mult(32'h1234_5678, 32'h0, 64'd0, "mb0");
        run_mult(32'h0, 32'hDEAD_BEEF, 64'd0, "ma0");
        run_mult(32'h8000_0000, 32'd2, 64'h1_0000_0000, "mmsb");

        // Starts during BUSY and DONE must be ignored.
        @(negedge clk);
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ign_lat", 64'(lat), 64'd32);
        chk("ign_prod", product, 64'd63);
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_done = 0;
        n_busy = 0;
        repeat (40) begin
            if (done) n_done++;
            if (busy) n_busy++;
            @(posedge clk);
            #1;
        end
        chk("ign_no_done", 64'(n_done), 64'd0);
        chk("ign_no_busy", 64'(n_busy), 64'd0);
        chk("ign_prod_hold", product, 64'd63);

        // Async reset mid-operation clears everything without waiting for an edge.
        @(negedge clk);
        start = 1'b1;
        a     = 32'd10;
        b     = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_prod", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mult(32'd6, 32'd7, 64'd42, "m6x7");

        // Start held high: one result every 34 edges, product steady in between.
        @(negedge clk);
        start    = 1'b1;
        a        = 32'd2;
        b        = 32'd3;
        n_done   = 0;
        unstable = 0;
        for (int i = 0; i < 4; i++) done_edge[i] = 0;
        e = 0;
        repeat (110) begin
            @(posedge clk);
            #1;
            e++;
            if (done) begin
                if (n_done < 4) done_edge[n_done] = e;
                n_done++;
            end
            if (n_done > 0 && product !== 64'd6) unstable++;
        end
        start = 1'b0;
        chk("hold_n_done", 64'(n_done), 64'd3);
        chk("hold_first", 64'(done_edge[0]), 64'd33);
        chk("hold_per1", 64'(done_edge[1] - done_edge[0]), 64'd34);
        chk("hold_per2", 64'(done_edge[2] - done_edge[1]), 64'd34);
        chk("hold_prod", product, 64'd6);
        chk("hold_stable", 64'(unstable), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
